// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_engine
// Purpose  : Convolution multiply-accumulate datapath. It takes the per-step
//            address tuples (window base, offset in window, kernel index),
//            reads the image and kernel buffers, multiplies, and sums
//            kern_count products per window. Each window sum goes into a
//            small result FIFO that is drained on a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst (synchronous, active-low)
//   ld_en/ld_sel/ld_addr/ld_data : buffer loading, accepted in IDLE only
//   start, kern_count, out_count : frame launch, counts latched in IDLE
//   step_valid/step_ready        : address tuple handshake
//   accu_shift, mul_shift, kirnal_shift : address tuple fields
//   out_valid/out_ready/out_data : result stream
//   busy (RUN or DRAIN), done (1-cycle pulse on the final window push)
// Configuration
//   CONV_SAT_EN : when defined, the accumulator saturates to the signed
//                 ACC_W range and holds the clamp until the window ends;
//                 otherwise it wraps modulo 2^ACC_W.
// ============================================================================
module conv_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int IMG_AW = 10,
  parameter int KER_AW = 6,
  parameter int FIFO_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [IMG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [5:0]        kern_count,
  input  logic [9:0]        out_count,
  input  logic              step_valid,
  output logic              step_ready,
  input  logic [4:0]        accu_shift,
  input  logic [4:0]        mul_shift,
  input  logic [5:0]        kirnal_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  localparam int FIFO_AW = $clog2(FIFO_D);
  localparam int CNT_W   = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  // frame configuration and progress
  logic [5:0] kern_lat;
  logic [9:0] out_lat;
  logic [5:0] k_idx;
  logic [9:0] win_idx;

  // pipeline
  logic              v1, last1, v2, last2;
  logic [IMG_AW-1:0] img_addr;
  logic [KER_AW-1:0] ker_addr;
  logic signed [DATA_W-1:0] img_q, ker_q;
  logic signed [ACC_W-1:0]  acc;

  // buffers
  logic [DATA_W-1:0] img_mem [0:(1<<IMG_AW)-1];
  logic [DATA_W-1:0] ker_mem [0:(1<<KER_AW)-1];

  // result FIFO
  logic [ACC_W-1:0]   fifo_mem [0:FIFO_D-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic accept, tuple_last, push, pop;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W:0]      sum_wide;
  logic signed [ACC_W-1:0]    sum_next;

  assign step_ready = (state == RUN) && (fifo_cnt <= CNT_W'(FIFO_D - 4));
  assign accept     = step_valid && step_ready;
  // kern_lat of 0 wraps to 63 here, so it behaves as a 64-product window
  assign tuple_last = (k_idx == kern_lat - 6'd1);
  assign push       = v2 && last2;
  assign out_valid  = (fifo_cnt != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy       = (state != IDLE);

  // one guard bit above ACC_W exposes signed overflow of the add
  assign prod     = img_q * ker_q;
  assign prod_ext = ACC_W'(prod);
  assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sat, sat_next;

  always_comb begin
    sat_next = sat;
    sum_next = sum_wide[ACC_W-1:0];
    if (sat) begin
      // once clamped, the window result is pinned to the clamp value
      sum_next = acc;
    end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sat_next = 1'b1;
      sum_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)    sat <= 1'b0;
    else if (v2) sat <= last2 ? 1'b0 : sat_next;
  end
`else
  always_comb begin
    sum_next = sum_wide[ACC_W-1:0];
  end
`endif

  // buffer writes (IDLE only) and synchronous reads
  always_ff @(posedge clk) begin
    if (rst && ld_en && state == IDLE) begin
      if (ld_sel) ker_mem[ld_addr[KER_AW-1:0]] <= ld_data;
      else        img_mem[ld_addr]             <= ld_data;
    end
    img_q <= img_mem[img_addr];
    ker_q <= ker_mem[ker_addr];
  end

  always_ff @(posedge clk) begin
    if (rst && push) fifo_mem[wr_ptr] <= sum_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      kern_lat <= '0;
      out_lat  <= '0;
      k_idx    <= '0;
      win_idx  <= '0;
      v1       <= 1'b0;
      last1    <= 1'b0;
      v2       <= 1'b0;
      last2    <= 1'b0;
      img_addr <= '0;
      ker_addr <= '0;
      acc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      v1    <= accept;
      last1 <= accept && tuple_last;
      if (accept) begin
        img_addr <= IMG_AW'(accu_shift) + IMG_AW'(mul_shift);
        ker_addr <= KER_AW'(kirnal_shift);
      end
      v2    <= v1;
      last2 <= v1 && last1;

      // the last product goes straight into the FIFO; acc restarts at 0
      if (v2) acc <= last2 ? '0 : sum_next;

      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            kern_lat <= kern_count;
            out_lat  <= out_count;
            k_idx    <= '0;
            win_idx  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (tuple_last) begin
              k_idx   <= '0;
              win_idx <= win_idx + 10'd1;
              if (win_idx + 10'd1 == out_lat) state <= DRAIN;
            end else begin
              k_idx <= k_idx + 6'd1;
            end
          end
        end
        DRAIN: begin
          // the final window's push is the one with nothing behind it
          if (push && !v1) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
